// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH product,
// one Booth step per clock, WIDTH clocks per operation.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst          - synchronous active-high reset
//   start        - begin a multiply (accepted in IDLE or DONE only)
//   multiplicand - signed operand M, sampled at the accepting edge
//   multiplier   - signed operand Q, sampled at the accepting edge
//   busy         - high while the Booth iterations run
//   done         - one-cycle pulse: product holds a new result
//   product      - signed M*Q, held until the next result
module booth_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Accumulator carries one guard bit so M = -2^(WIDTH-1) never overflows.
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   a_nxt;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic             qm1;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last      = (cnt == CW'(WIDTH - 1));
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One Booth step followed by the arithmetic right shift of {A, Q, Q(-1)}.
    always_comb begin
        addend = {m[WIDTH-1], m};
        sum    = a;
        unique case ({q[0], qm1})
            2'b01:   sum = a + addend;
            2'b10:   sum = a - addend;
            default: sum = a;
        endcase
        a_nxt = {sum[WIDTH], sum[WIDTH:1]};
        q_nxt = {sum[0], q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a       <= '0;
            q       <= '0;
            qm1     <= 1'b0;
            m       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                m   <= multiplicand;
                q   <= multiplier;
                a   <= '0;
                qm1 <= 1'b0;
                cnt <= '0;
            end else if (state == RUN) begin
                a   <= a_nxt;
                q   <= q_nxt;
                qm1 <= q[0];
                cnt <= cnt + CW'(1);
                if (last) begin
                    product <= {a_nxt[WIDTH-1:0], q_nxt};
                end
            end
        end
    end

endmodule
